// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// UartRx: 8N1 UART receiver.
//
// Oversamples the serial line at CYCLES_PER_BIT clocks per bit, recovers each
// byte LSB-first and presents it to the consumer through a valid/ready
// holding register. Framing errors and overruns are reported as one-cycle
// pulses.
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   rst             synchronous, active-high reset
//   in__rx          serial line (idles high, asynchronous to clk)
//   in__ready       consumer can take out__data this cycle
//   out__data       received byte, stable while out__valid is high
//   out__valid      out__data holds an unconsumed byte
//   out__frame_err  one-cycle pulse: stop bit sampled low
//   out__overrun    one-cycle pulse: good byte dropped, holding register full
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CYCLES_PER_BIT = 25,
    parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in__rx,
    input  logic       in__ready,
    output logic [7:0] out__data,
    output logic       out__valid,
    output logic       out__frame_err,
    output logic       out__overrun
);

    localparam int CTR_W = $clog2(CYCLES_PER_BIT);
    localparam logic [CTR_W-1:0] HALF_MARK = CTR_W'(HALF_BIT);
    localparam logic [CTR_W-1:0] BIT_LAST  = CTR_W'(CYCLES_PER_BIT - 1);
    localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frameErr_q, frameErr_d;
    logic             overrun_q, overrun_d;
    logic             rxMeta_q, rxSync_q;
    logic             deliver;
    logic             transfer;

    // Two-flop synchronizer for the asynchronous serial line plus every
    // piece of receiver state. The synchronizer resets to the idle (high)
    // level so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q   <= 1'b1;
            rxSync_q   <= 1'b1;
            state_q    <= IDLE;
            ctr_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rxMeta_q   <= in__rx;
            rxSync_q   <= rxMeta_q;
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
        end
    end

    // Frame FSM. The start bit is re-checked half a bit after the falling
    // edge to reject glitches; from then on every sample lands a whole bit
    // period later, i.e. near the middle of each bit. The FSM goes back to
    // IDLE straight after the stop sample so a start edge that follows the
    // stop bit immediately is still caught. A stop bit sampled low parks
    // the FSM in BREAK so a line held low reports only one error.
    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        deliver    = 1'b0;
        frameErr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxSync_q) begin
                    state_d = START;
                    ctr_d   = '0;
                end
            end
            START: begin
                if (ctr_q == HALF_MARK) begin
                    ctr_d = '0;
                    if (rxSync_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_ONE;
                end
            end
            DATA: begin
                if (ctr_q == BIT_LAST) begin
                    ctr_d   = '0;
                    shift_d = {rxSync_q, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_ONE;
                end
            end
            STOP: begin
                if (ctr_q == BIT_LAST) begin
                    ctr_d = '0;
                    if (rxSync_q) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = BREAK;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_ONE;
                end
            end
            BREAK: begin
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ctr_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Holding register. A byte delivered in the same cycle the consumer
    // takes the old one replaces it seamlessly; a byte arriving while the
    // old one is still unconsumed is dropped and flagged as an overrun.
    always_comb begin
        transfer  = valid_q && in__ready;
        valid_d   = valid_q && !transfer;
        data_d    = data_q;
        overrun_d = 1'b0;
        if (deliver) begin
            if (!valid_q || transfer) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign out__data      = data_q;
    assign out__valid     = valid_q;
    assign out__frame_err = frameErr_q;
    assign out__overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// TbUartRx: directed testbench for uart_rx at default parameters.
//
// Drives 8N1 frames onto in__rx the way the upstream transmitter does (25
// clocks per bit, inputs changed on the falling clock edge) and checks
// received bytes, their arrival cycle, and the error pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB     = 25;
    localparam int LATENCY = 240;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frameErr;
    logic       overrun;

    int compared   = 0;
    int mismatched = 0;

    uart_rx #(
        .CYCLES_PER_BIT(CPB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in__rx        (rx),
        .in__ready     (ready),
        .out__data     (data),
        .out__valid    (valid),
        .out__frame_err(frameErr),
        .out__overrun  (overrun)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Cycle number of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor on the falling edge: logs every rising edge of out__valid
    // with its byte and cycle, and tallies valid cycles and error pulses.
    logic [7:0] riseData[$];
    int         riseCyc[$];
    int         validCycles   = 0;
    int         frameErrCount = 0;
    int         frameErrCyc   = 0;
    int         overrunCount  = 0;
    int         overrunCyc    = 0;
    logic       prevValid     = 1'b0;

    always @(negedge clk) begin
        if (valid && !prevValid) begin
            riseData.push_back(data);
            riseCyc.push_back(cyc);
        end
        if (valid) validCycles++;
        if (frameErr) begin
            frameErrCount++;
            frameErrCyc = cyc;
        end
        if (overrun) begin
            overrunCount++;
            overrunCyc = cyc;
        end
        prevValid = valid;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one frame starting at the current falling edge and returns on
    // the falling edge right after the stop bit. startEdge is the rising
    // edge at which the start bit is first sampled low.
    task automatic applyStimulus(input logic [7:0] value, input logic stopLevel,
                                 output int startEdge);
        rx        = 1'b0;
        startEdge = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = value[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopLevel;
        repeat (CPB) @(negedge clk);
    endtask

    int e0, e1, e2;
    int baseRise, baseValid, baseFe, baseOv;

    task automatic snapshot();
        baseRise  = riseData.size();
        baseValid = validCycles;
        baseFe    = frameErrCount;
        baseOv    = overrunCount;
    endtask

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_data", 32'(data), 32'h0);
        checkOutput("reset_frame_err", 32'(frameErr), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte loopback.
        snapshot();
        applyStimulus(8'hA5, 1'b1, e0);
        repeat (10) @(negedge clk);
        checkOutput("a5_count", 32'(riseData.size() - baseRise), 32'd1);
        checkOutput("a5_data", 32'(riseData[baseRise]), 32'hA5);
        checkOutput("a5_latency", 32'(riseCyc[baseRise]), 32'(e0 + LATENCY));
        checkOutput("a5_valid_cycles", 32'(validCycles - baseValid), 32'd1);
        checkOutput("a5_frame_err", 32'(frameErrCount - baseFe), 32'd0);
        checkOutput("a5_overrun", 32'(overrunCount - baseOv), 32'd0);

        // Back-to-back frames.
        snapshot();
        applyStimulus(8'h00, 1'b1, e0);
        applyStimulus(8'hFF, 1'b1, e1);
        applyStimulus(8'h3C, 1'b1, e2);
        repeat (10) @(negedge clk);
        checkOutput("b2b_count", 32'(riseData.size() - baseRise), 32'd3);
        checkOutput("b2b_data0", 32'(riseData[baseRise]), 32'h00);
        checkOutput("b2b_data1", 32'(riseData[baseRise + 1]), 32'hFF);
        checkOutput("b2b_data2", 32'(riseData[baseRise + 2]), 32'h3C);
        checkOutput("b2b_cyc0", 32'(riseCyc[baseRise]), 32'(e0 + LATENCY));
        checkOutput("b2b_cyc1", 32'(riseCyc[baseRise + 1]), 32'(e1 + LATENCY));
        checkOutput("b2b_cyc2", 32'(riseCyc[baseRise + 2]), 32'(e2 + LATENCY));
        checkOutput("b2b_errors", 32'(frameErrCount - baseFe + overrunCount - baseOv), 32'd0);

        // Glitch shorter than half a bit, then a real frame.
        snapshot();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_no_valid", 32'(riseData.size() - baseRise), 32'd0);
        checkOutput("glitch_no_err", 32'(frameErrCount - baseFe + overrunCount - baseOv), 32'd0);
        applyStimulus(8'h81, 1'b1, e0);
        repeat (10) @(negedge clk);
        checkOutput("glitch_next_count", 32'(riseData.size() - baseRise), 32'd1);
        checkOutput("glitch_next_data", 32'(riseData[baseRise]), 32'h81);
        checkOutput("glitch_next_cyc", 32'(riseCyc[baseRise]), 32'(e0 + LATENCY));

        // Framing error followed by a held-low line, then a good frame.
        snapshot();
        applyStimulus(8'h55, 1'b0, e0);
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("ferr_count", 32'(frameErrCount - baseFe), 32'd1);
        checkOutput("ferr_cyc", 32'(frameErrCyc), 32'(e0 + LATENCY));
        checkOutput("ferr_no_valid", 32'(riseData.size() - baseRise), 32'd0);
        checkOutput("ferr_no_overrun", 32'(overrunCount - baseOv), 32'd0);
        applyStimulus(8'h12, 1'b1, e0);
        repeat (10) @(negedge clk);
        checkOutput("ferr_next_count", 32'(riseData.size() - baseRise), 32'd1);
        checkOutput("ferr_next_data", 32'(riseData[baseRise]), 32'h12);
        checkOutput("ferr_next_cyc", 32'(riseCyc[baseRise]), 32'(e0 + LATENCY));
        checkOutput("ferr_still_one", 32'(frameErrCount - baseFe), 32'd1);

        // Overrun: consumer stalled across two frames.
        snapshot();
        ready = 1'b0;
        applyStimulus(8'h11, 1'b1, e0);
        applyStimulus(8'h22, 1'b1, e1);
        repeat (10) @(negedge clk);
        checkOutput("ovr_count", 32'(overrunCount - baseOv), 32'd1);
        checkOutput("ovr_cyc", 32'(overrunCyc), 32'(e1 + LATENCY));
        checkOutput("ovr_held_data", 32'(data), 32'h11);
        checkOutput("ovr_held_valid", 32'(valid), 32'h1);
        checkOutput("ovr_rises", 32'(riseData.size() - baseRise), 32'd1);
        checkOutput("ovr_first_cyc", 32'(riseCyc[baseRise]), 32'(e0 + LATENCY));
        checkOutput("ovr_no_ferr", 32'(frameErrCount - baseFe), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        checkOutput("ovr_drain_valid", 32'(valid), 32'h0);
        checkOutput("ovr_drain_data", 32'(data), 32'h11);

        // Reset during data bit 3 while a byte is held.
        ready = 1'b0;
        applyStimulus(8'h77, 1'b1, e0);
        repeat (5) @(negedge clk);
        checkOutput("rst_pre_valid", 32'(valid), 32'h1);
        checkOutput("rst_pre_data", 32'(data), 32'h77);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        checkOutput("rst_mid_valid", 32'(valid), 32'h0);
        checkOutput("rst_mid_data", 32'(data), 32'h0);
        snapshot();
        repeat (300) @(negedge clk);
        checkOutput("rst_quiet_valid", 32'(riseData.size() - baseRise), 32'd0);
        checkOutput("rst_quiet_pulses", 32'(frameErrCount - baseFe + overrunCount - baseOv), 32'd0);
        ready = 1'b1;
        applyStimulus(8'hC3, 1'b1, e0);
        repeat (10) @(negedge clk);
        checkOutput("rst_next_count", 32'(riseData.size() - baseRise), 32'd1);
        checkOutput("rst_next_data", 32'(riseData[baseRise]), 32'hC3);
        checkOutput("rst_next_cyc", 32'(riseCyc[baseRise]), 32'(e0 + LATENCY));
        checkOutput("rst_next_errors", 32'(frameErrCount - baseFe + overrunCount - baseOv), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
